// File: rtl/hazard_forwarding_ctrl_pkg.sv
// Shared definitions for the RV32I forwarding/hazard unit: forward codes,
// result-source encodings and the default-width shadow-slot layout.
package rv_hazard_pkg;

  localparam int unsigned RV_REG_AW = 5;
  localparam int unsigned RV_SEL_W  = 2;
  localparam int unsigned RV_FWD_W  = 3;

  typedef enum logic [2:0] {
    FWD_NONE        = 3'b000,
    FWD_EXMEM_ALU   = 3'b001,
    FWD_EXMEM_OTHER = 3'b010,
    FWD_MEMWB_ALU   = 3'b011,
    FWD_MEMWB_OTHER = 3'b100
  } fwd_code_t;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_PC4  = 2'b01,
    RES_LOAD = 2'b10,
    RES_RSVD = 2'b11
  } res_sel_t;

  typedef struct packed {
    logic                valid;
    logic                we;
    logic [RV_REG_AW-1:0] rd;
    logic [RV_SEL_W-1:0]  sel;
  } slot_t;

  localparam int unsigned SLOT_W = $bits(slot_t);

endpackage

// File: rtl/hazard_forwarding_ctrl_if.sv
// ID-stage decode info in, stall request / EXE forward selects / stall counter out.
interface hazard_forwarding_ctrl_if #(
  parameter int unsigned NUM_RS = 2,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned FWD_W  = 3,
  parameter int unsigned CNT_W  = 16
);
  logic                     id_valid;
  logic [NUM_RS*REG_AW-1:0] id_rs_addr;
  logic [NUM_RS-1:0]        id_rs_used;
  logic                     id_rd_we;
  logic [REG_AW-1:0]        id_rd_addr;
  logic [SEL_W-1:0]         id_res_sel;
  logic                     flush_exe;
  logic                     ext_stall;
  logic                     stall_id;
  logic [NUM_RS*FWD_W-1:0]  fwd_ctrl_exe;
  logic [CNT_W-1:0]         stall_count;

  modport master (
    output id_valid, id_rs_addr, id_rs_used, id_rd_we, id_rd_addr, id_res_sel,
           flush_exe, ext_stall,
    input  stall_id, fwd_ctrl_exe, stall_count
  );

  modport slave (
    input  id_valid, id_rs_addr, id_rs_used, id_rd_we, id_rd_addr, id_res_sel,
           flush_exe, ext_stall,
    output stall_id, fwd_ctrl_exe, stall_count
  );
endinterface

// File: rtl/hazard_forwarding_ctrl_fwd_match.sv
// Per-operand priority compare of one ID source against the EXE and MEM slots.
module fwd_match
  import rv_hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned SEL_W  = 2
) (
  input  logic              rs_used,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic              exe_occ,
  input  logic [REG_AW-1:0] exe_rd,
  input  logic [SEL_W-1:0]  exe_sel,
  input  logic              mem_occ,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [SEL_W-1:0]  mem_sel,
  output fwd_code_t         code,
  output logic              load_hazard
);

  always_comb begin
    code        = FWD_NONE;
    load_hazard = 1'b0;
    if (rs_used && rs_addr != '0) begin
      // EXE is the younger producer, so it shadows any MEM match
      if (exe_occ && exe_rd == rs_addr) begin
        if (exe_sel == SEL_W'(RES_LOAD))     load_hazard = 1'b1;
        else if (exe_sel == SEL_W'(RES_ALU)) code = FWD_EXMEM_ALU;
        else                                 code = FWD_EXMEM_OTHER;
      end else if (mem_occ && mem_rd == rs_addr) begin
        code = (mem_sel == SEL_W'(RES_ALU)) ? FWD_MEMWB_ALU : FWD_MEMWB_OTHER;
      end
    end
  end

endmodule

// File: rtl/hazard_forwarding_ctrl.sv
// Forwarding/hazard unit: tracks in-flight destinations, registers EXE forward
// selects, raises load-use stalls and counts stall cycles (saturating).
module hazard_forwarding_ctrl
  import rv_hazard_pkg::*;
#(
  parameter int unsigned NUM_RS = 2,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned FWD_W  = 3,
  parameter int unsigned CNT_W  = 16
) (
  input logic                    clk,
  input logic                    rst,
  hazard_forwarding_ctrl_if.slave bus
);

  typedef struct packed {
    logic              valid;
    logic              we;
    logic [REG_AW-1:0] rd;
    logic [SEL_W-1:0]  sel;
  } pslot_t;

  // The WB stage is not tracked: the regfile is write-before-read, so a WB
  // producer never needs a forward code.
  pslot_t                  exe_slot, mem_slot;
  logic                    exe_occ, mem_occ;
  logic [NUM_RS-1:0]       hazard;
  logic [NUM_RS*FWD_W-1:0] codes;
  logic [NUM_RS*FWD_W-1:0] fwd_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    stall;
  logic                    issue;

  assign exe_occ = exe_slot.valid && exe_slot.we && exe_slot.rd != '0;
  assign mem_occ = mem_slot.valid && mem_slot.we && mem_slot.rd != '0;

  for (genvar i = 0; i < NUM_RS; i++) begin : g_op
    fwd_code_t code;
    fwd_match #(.REG_AW(REG_AW), .SEL_W(SEL_W)) u_match (
      .rs_used     (bus.id_rs_used[i]),
      .rs_addr     (bus.id_rs_addr[i*REG_AW +: REG_AW]),
      .exe_occ     (exe_occ),
      .exe_rd      (exe_slot.rd),
      .exe_sel     (exe_slot.sel),
      .mem_occ     (mem_occ),
      .mem_rd      (mem_slot.rd),
      .mem_sel     (mem_slot.sel),
      .code        (code),
      .load_hazard (hazard[i])
    );
    assign codes[i*FWD_W +: FWD_W] = FWD_W'(code);
  end

  assign stall = (|hazard) && bus.id_valid && !bus.flush_exe;
  assign issue = bus.id_valid && !stall && !bus.flush_exe;

  always_ff @(posedge clk) begin
    if (rst) begin
      exe_slot <= '0;
      mem_slot <= '0;
      fwd_q    <= '0;
      cnt_q    <= '0;
    end else begin
      if (stall && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
      if (!bus.ext_stall) begin
        mem_slot <= exe_slot;
        if (issue) begin
          exe_slot <= '{valid: 1'b1, we: bus.id_rd_we, rd: bus.id_rd_addr, sel: bus.id_res_sel};
          fwd_q    <= codes;
        end else begin
          exe_slot <= '0;
          fwd_q    <= '0;
        end
      end
    end
  end

  assign bus.stall_id     = stall;
  assign bus.fwd_ctrl_exe = fwd_q;
  assign bus.stall_count  = cnt_q;

endmodule

// File: tb/tb_hazard_forwarding_ctrl.sv
// Directed bench for hazard_forwarding_ctrl; a second CNT_W=2 instance mirrors
// the same stimulus to exercise counter saturation.
module tb_hazard_forwarding_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  hazard_forwarding_ctrl_if bus ();
  hazard_forwarding_ctrl_if #(.CNT_W(2)) bus_s ();

  assign bus_s.id_valid   = bus.id_valid;
  assign bus_s.id_rs_addr = bus.id_rs_addr;
  assign bus_s.id_rs_used = bus.id_rs_used;
  assign bus_s.id_rd_we   = bus.id_rd_we;
  assign bus_s.id_rd_addr = bus.id_rd_addr;
  assign bus_s.id_res_sel = bus.id_res_sel;
  assign bus_s.flush_exe  = bus.flush_exe;
  assign bus_s.ext_stall  = bus.ext_stall;

  hazard_forwarding_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  hazard_forwarding_ctrl #(.CNT_W(2)) dut_s (.clk(clk), .rst(rst), .bus(bus_s));

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs0, input logic u0,
                        input logic [4:0] rs1, input logic u1,
                        input logic we, input logic [4:0] rd, input logic [1:0] sel);
    bus.id_valid   = v;
    bus.id_rs_addr = {rs1, rs0};
    bus.id_rs_used = {u1, u0};
    bus.id_rd_we   = we;
    bus.id_rd_addr = rd;
    bus.id_res_sel = sel;
  endtask

  task automatic nop(input int n);
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 2'b00);
    step(n);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.flush_exe = 1'b0;
    bus.ext_stall = 1'b0;
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 2'b00);
    step(2);
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.stall_id !== 1'b0) begin miscompares++; $display("FAIL reset_stall got=%b exp=0", bus.stall_id); end
    vectors++;
    if (bus.fwd_ctrl_exe !== 6'b0) begin miscompares++; $display("FAIL reset_fwd got=%b exp=000000", bus.fwd_ctrl_exe); end
    vectors++;
    if (bus.stall_count !== 16'd0) begin miscompares++; $display("FAIL reset_cnt got=%0d exp=0", bus.stall_count); end
  endtask

  task automatic test_alu_fwd;
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd5, 2'b00);
    step();
    set_id(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b1, 5'd8, 2'b00);
    #1;
    vectors++;
    if (bus.stall_id !== 1'b0) begin miscompares++; $display("FAIL alu_nostall got=%b exp=0", bus.stall_id); end
    step();
    vectors++;
    if (bus.fwd_ctrl_exe !== 6'b000_001) begin miscompares++; $display("FAIL alu_fwd got=%b exp=000001", bus.fwd_ctrl_exe); end
    nop(3);
  endtask

  task automatic test_load_use;
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd7, 2'b10);
    step();
    set_id(1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b1, 5'd10, 2'b00);
    #1;
    vectors++;
    if (bus.stall_id !== 1'b1) begin miscompares++; $display("FAIL lu_stall got=%b exp=1", bus.stall_id); end
    step();
    vectors++;
    if (bus.fwd_ctrl_exe !== 6'b0) begin miscompares++; $display("FAIL lu_bubble got=%b exp=000000", bus.fwd_ctrl_exe); end
    vectors++;
    if (bus.stall_id !== 1'b0) begin miscompares++; $display("FAIL lu_release got=%b exp=0", bus.stall_id); end
    vectors++;
    if (bus.stall_count !== 16'd1) begin miscompares++; $display("FAIL lu_cnt got=%0d exp=1", bus.stall_count); end
    step();
    vectors++;
    if (bus.fwd_ctrl_exe !== 6'b100_000) begin miscompares++; $display("FAIL lu_fwd got=%b exp=100000", bus.fwd_ctrl_exe); end
    nop(3);
  endtask

  task automatic test_memwb;
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 2'b01);
    step();
    nop(1);
    set_id(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 5'd12, 2'b00);
    step();
    vectors++;
    if (bus.fwd_ctrl_exe !== 6'b000_100) begin miscompares++; $display("FAIL memwb_other got=%b exp=000100", bus.fwd_ctrl_exe); end
    nop(3);
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd9, 2'b00);
    step();
    nop(1);
    set_id(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 5'd12, 2'b00);
    step();
    vectors++;
    if (bus.fwd_ctrl_exe !== 6'b000_011) begin miscompares++; $display("FAIL memwb_alu got=%b exp=000011", bus.fwd_ctrl_exe); end
    nop(3);
  endtask

  task automatic test_priority_x0;
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd11, 2'b00);
    step();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd11, 2'b01);
    step();
    set_id(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 2'b00);
    step();
    vectors++;
    if (bus.fwd_ctrl_exe !== 6'b000_010) begin miscompares++; $display("FAIL prio_exe got=%b exp=000010", bus.fwd_ctrl_exe); end
    nop(3);
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 2'b10);
    step();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 2'b00);
    #1;
    vectors++;
    if (bus.stall_id !== 1'b0) begin miscompares++; $display("FAIL x0_stall got=%b exp=0", bus.stall_id); end
    step();
    vectors++;
    if (bus.fwd_ctrl_exe !== 6'b0) begin miscompares++; $display("FAIL x0_fwd got=%b exp=000000", bus.fwd_ctrl_exe); end
    nop(3);
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd12, 2'b10);
    step();
    set_id(1'b1, 5'd12, 1'b0, 5'd12, 1'b0, 1'b0, 5'd0, 2'b00);
    #1;
    vectors++;
    if (bus.stall_id !== 1'b0) begin miscompares++; $display("FAIL unused_stall got=%b exp=0", bus.stall_id); end
    step();
    vectors++;
    if (bus.fwd_ctrl_exe !== 6'b0) begin miscompares++; $display("FAIL unused_fwd got=%b exp=000000", bus.fwd_ctrl_exe); end
    nop(3);
  endtask

  task automatic test_flush_ext_stall;
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd3, 2'b10);
    step();
    set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 5'd13, 2'b00);
    bus.flush_exe = 1'b1;
    #1;
    vectors++;
    if (bus.stall_id !== 1'b0) begin miscompares++; $display("FAIL flush_stall got=%b exp=0", bus.stall_id); end
    step();
    bus.flush_exe = 1'b0;
    vectors++;
    if (bus.fwd_ctrl_exe !== 6'b0) begin miscompares++; $display("FAIL flush_bubble got=%b exp=000000", bus.fwd_ctrl_exe); end
    vectors++;
    if (bus.stall_count !== 16'd1) begin miscompares++; $display("FAIL flush_cnt got=%0d exp=1", bus.stall_count); end
    set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 5'd4, 2'b00);
    step();
    vectors++;
    if (bus.fwd_ctrl_exe !== 6'b000_100) begin miscompares++; $display("FAIL flush_after got=%b exp=000100", bus.fwd_ctrl_exe); end
    bus.ext_stall = 1'b1;
    set_id(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 2'b00);
    for (int c = 0; c < 3; c++) begin
      step();
      vectors++;
      if (bus.fwd_ctrl_exe !== 6'b000_100) begin miscompares++; $display("FAIL ext_hold%0d got=%b exp=000100", c, bus.fwd_ctrl_exe); end
    end
    bus.ext_stall = 1'b0;
    step();
    vectors++;
    if (bus.fwd_ctrl_exe !== 6'b000_001) begin miscompares++; $display("FAIL ext_slots got=%b exp=000001", bus.fwd_ctrl_exe); end
    nop(3);
  endtask

  task automatic load_use_once;
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd7, 2'b10);
    step();
    set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 2'b00);
    step(2);
    nop(1);
  endtask

  task automatic test_saturate_reset;
    load_use_once();
    load_use_once();
    vectors++;
    if (bus_s.stall_count !== 2'd3) begin miscompares++; $display("FAIL sat_mid got=%0d exp=3", bus_s.stall_count); end
    vectors++;
    if (bus.stall_count !== 16'd3) begin miscompares++; $display("FAIL cnt_mid got=%0d exp=3", bus.stall_count); end
    for (int k = 0; k < 3; k++) load_use_once();
    vectors++;
    if (bus_s.stall_count !== 2'd3) begin miscompares++; $display("FAIL sat_end got=%0d exp=3", bus_s.stall_count); end
    vectors++;
    if (bus.stall_count !== 16'd6) begin miscompares++; $display("FAIL cnt_end got=%0d exp=6", bus.stall_count); end
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd7, 2'b10);
    step();
    set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 2'b00);
    #1;
    vectors++;
    if (bus.stall_id !== 1'b1) begin miscompares++; $display("FAIL rst_pre got=%b exp=1", bus.stall_id); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.stall_id !== 1'b0) begin miscompares++; $display("FAIL rst_stall got=%b exp=0", bus.stall_id); end
    vectors++;
    if (bus.stall_count !== 16'd0 || bus_s.stall_count !== 2'd0) begin
      miscompares++;
      $display("FAIL rst_cnt got=%0d/%0d exp=0/0", bus.stall_count, bus_s.stall_count);
    end
    vectors++;
    if (bus.fwd_ctrl_exe !== 6'b0) begin miscompares++; $display("FAIL rst_fwd got=%b exp=000000", bus.fwd_ctrl_exe); end
  endtask

  initial begin
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_memwb();
    test_priority_x0();
    test_flush_ext_stall();
    test_saturate_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
